// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier with parametrised exponent/fraction widths,
// round-to-nearest-even, DAZ/FTZ, special values, exception flags and valid/ready backpressure.
module fp_mul_pipe #(
   parameter int unsigned EXP_W  = 11,
   parameter int unsigned FRAC_W = 52,
   localparam int unsigned W     = EXP_W + FRAC_W + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic [3:0]   flags
);

   localparam int unsigned MW   = FRAC_W + 1;
   localparam int unsigned PW   = 2 * MW;
   localparam int unsigned XW   = EXP_W + 2;
   localparam int unsigned BIAS = (2 ** (EXP_W - 1)) - 1;
   localparam logic signed [XW-1:0] MAX_E = XW'((2 ** EXP_W) - 1);
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

   // Stage enables: a stage may load when it is empty or its contents move on
   logic s1_valid, s2_valid;
   logic s1_en, s2_en, s3_en;

   assign s3_en     = !out_valid | out_ready;
   assign s2_en     = !s2_valid | s3_en;
   assign s1_en     = !s1_valid | s2_en;
   assign in_ready  = s1_en;

   // Operand decode; a zero exponent field means zero (subnormals flushed)
   logic               a_sign, b_sign, p_sign;
   logic [EXP_W-1:0]   a_exp, b_exp;
   logic [FRAC_W-1:0]  a_frac, b_frac;
   logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;

   assign a_sign = a[W-1];
   assign b_sign = b[W-1];
   assign a_exp  = a[W-2:FRAC_W];
   assign b_exp  = b[W-2:FRAC_W];
   assign a_frac = a[FRAC_W-1:0];
   assign b_frac = b[FRAC_W-1:0];
   assign p_sign = a_sign ^ b_sign;
   assign a_zero = (a_exp == '0);
   assign b_zero = (b_exp == '0);
   assign a_inf  = (&a_exp) & (a_frac == '0);
   assign b_inf  = (&b_exp) & (b_frac == '0);
   assign a_nan  = (&a_exp) & (|a_frac);
   assign b_nan  = (&b_exp) & (|b_frac);
   assign a_snan = a_nan & !a_frac[FRAC_W-1];
   assign b_snan = b_nan & !b_frac[FRAC_W-1];

   // Special-operand result, resolved up front and carried alongside the datapath
   logic         sp_hit;
   logic [W-1:0] sp_res;
   logic [3:0]   sp_flg;

   always_comb begin
      sp_hit = 1'b1;
      sp_res = '0;
      sp_flg = '0;
      if (a_nan | b_nan) begin
         sp_res = QNAN;
         sp_flg = {a_snan | b_snan, 3'b000};
      end else if ((a_inf & b_zero) | (a_zero & b_inf)) begin
         sp_res = QNAN;
         sp_flg = 4'b1000;
      end else if (a_inf | b_inf) begin
         sp_res = {p_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end else if (a_zero | b_zero) begin
         sp_res = {p_sign, {(W-1){1'b0}}};
      end else begin
         sp_hit = 1'b0;
      end
   end

   logic               s1_sign, s1_sp;
   logic [W-1:0]       s1_sp_res;
   logic [3:0]         s1_sp_flg;
   logic [EXP_W-1:0]   s1_ea, s1_eb;
   logic [MW-1:0]      s1_ma, s1_mb;

   logic               s2_sign, s2_sp;
   logic [W-1:0]       s2_sp_res;
   logic [3:0]         s2_sp_flg;
   logic [XW-1:0]      s2_exp;
   logic [PW-1:0]      s2_prod;

   // S3 normalise, round-to-nearest-even, renormalise and pack
   logic               msb, guard, sticky, rnd, carry, inexact;
   logic [PW-1:0]      norm;
   logic [MW-1:0]      sig;
   logic [MW:0]        sum;
   logic [FRAC_W-1:0]  frac_r;
   logic [XW-1:0]      exp_r;
   logic [W-1:0]       res_c;
   logic [3:0]         flg_c;

   assign msb     = s2_prod[PW-1];
   assign norm    = msb ? s2_prod : {s2_prod[PW-2:0], 1'b0};
   assign sig     = norm[PW-1:FRAC_W+1];
   assign guard   = norm[FRAC_W];
   assign sticky  = |norm[FRAC_W-1:0];
   assign rnd     = guard & (sticky | sig[0]);
   assign sum     = {1'b0, sig} + (MW+1)'(rnd);
   assign carry   = sum[MW];
   assign frac_r  = carry ? sum[FRAC_W:1] : sum[FRAC_W-1:0];
   assign exp_r   = s2_exp + XW'(msb) + XW'(carry);
   assign inexact = guard | sticky;

   always_comb begin
      res_c = '0;
      flg_c = '0;
      if (s2_sp) begin
         res_c = s2_sp_res;
         flg_c = s2_sp_flg;
      end else if ($signed(exp_r) >= MAX_E) begin
         res_c = {s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         flg_c = 4'b0101;
      end else if ($signed(exp_r) <= 0) begin
         res_c = {s2_sign, {(W-1){1'b0}}};
         flg_c = 4'b0011;
      end else begin
         res_c = {s2_sign, exp_r[EXP_W-1:0], frac_r};
         flg_c = {3'b000, inexact};
      end
   end

   // Pipeline registers; synchronous reset drops everything in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_sign   <= 1'b0;
         s1_sp     <= 1'b0;
         s1_sp_res <= '0;
         s1_sp_flg <= '0;
         s1_ea     <= '0;
         s1_eb     <= '0;
         s1_ma     <= '0;
         s1_mb     <= '0;
         s2_valid  <= 1'b0;
         s2_sign   <= 1'b0;
         s2_sp     <= 1'b0;
         s2_sp_res <= '0;
         s2_sp_flg <= '0;
         s2_exp    <= '0;
         s2_prod   <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
      end else begin
         if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_sign   <= p_sign;
               s1_sp     <= sp_hit;
               s1_sp_res <= sp_res;
               s1_sp_flg <= sp_flg;
               s1_ea     <= a_exp;
               s1_eb     <= b_exp;
               s1_ma     <= {1'b1, a_frac};
               s1_mb     <= {1'b1, b_frac};
            end
         end
         if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_sign   <= s1_sign;
               s2_sp     <= s1_sp;
               s2_sp_res <= s1_sp_res;
               s2_sp_flg <= s1_sp_flg;
               s2_exp    <= XW'(s1_ea) + XW'(s1_eb) - XW'(BIAS);
               s2_prod   <= PW'(s1_ma) * PW'(s1_mb);
            end
         end
         if (s3_en) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
               result <= res_c;
               flags  <= flg_c;
            end
         end
      end
   end

endmodule
